// File: rtl/mem_pkg.sv
// Shared types and constants for the data_memory block and its storage array.
package mem_pkg;

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} mem_state_t;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

endpackage

// File: rtl/mem_array.sv
// Single-port storage: synchronous write, registered read, selectable
// old/new data when a read and write hit the same port in one cycle.
module mem_array #(
  parameter int A = 6,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic         re,
  input  logic         rdw_new,
  input  logic [A-1:0] addr,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata
);

  localparam int DEPTH = 2 ** A;

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_d;
  logic [W-1:0] rdata_q;

  // Read data selection; holds the previous word when no read is issued.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      if (we && rdw_new) begin
        rdata_d = wdata;
      end else begin
        rdata_d = mem_q[addr];
      end
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Storage write port; contents are not reset, the clear sequence handles that.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= {W{1'b0}};
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_memory.sv
// Data memory with valid/ready request port, 1-cycle registered read and an
// optional post-reset clear sequence that zeroes every word.
module data_memory #(
  parameter int A              = 6,
  parameter int W              = 8,
  parameter int CLEAR_ON_RESET = 1,
  parameter int RDW_MODE       = 0
) (
  input  logic         clk,
  input  logic         reset,
  output logic         ready,
  input  logic         req_valid,
  input  logic         req_we,
  input  logic [A-1:0] req_addr,
  input  logic [W-1:0] req_wdata,
  output logic         rsp_valid,
  output logic [W-1:0] rsp_rdata
);

  import mem_pkg::*;

  localparam int         DEPTH       = 2 ** A;
  localparam logic [A:0] CNT_LAST    = (A + 1)'(DEPTH - 1);
  localparam logic [A:0] CNT_ONE     = {{A{1'b0}}, 1'b1};
  localparam mem_state_t START_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
  localparam logic       RDW_NEW     = (RDW_MODE == RDW_WRITE_FIRST) ? 1'b1 : 1'b0;

  mem_state_t   state_d, state_q;
  logic [A:0]   cnt_d, cnt_q;
  logic         rsp_valid_d, rsp_valid_q;
  logic         arr_we;
  logic         arr_re;
  logic [A-1:0] arr_addr;
  logic [W-1:0] arr_wdata;

  // Next-state, clear counter and write-port mux (clear sweep vs. request).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    arr_we      = 1'b0;
    arr_re      = 1'b0;
    arr_addr    = req_addr;
    arr_wdata   = req_wdata;
    case (state_q)
      CLEAR: begin
        arr_we    = 1'b1;
        arr_addr  = cnt_q[A-1:0];
        arr_wdata = {W{1'b0}};
        cnt_d     = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = RUN;
        end else begin
          state_d = CLEAR;
        end
      end
      RUN: begin
        arr_we      = req_valid & req_we;
        arr_re      = req_valid;
        rsp_valid_d = req_valid;
      end
      default: begin
        state_d = START_STATE;
        cnt_d   = {(A + 1){1'b0}};
      end
    endcase
    // Reset wins over everything: no write, no accept, clear restarts.
    if (reset) begin
      state_d     = START_STATE;
      cnt_d       = {(A + 1){1'b0}};
      rsp_valid_d = 1'b0;
      arr_we      = 1'b0;
      arr_re      = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    state_q     <= state_d;
    cnt_q       <= cnt_d;
    rsp_valid_q <= rsp_valid_d;
  end

  mem_array #(
    .A(A),
    .W(W)
  ) u_array (
    .clk    (clk),
    .reset  (reset),
    .we     (arr_we),
    .re     (arr_re),
    .rdw_new(RDW_NEW),
    .addr   (arr_addr),
    .wdata  (arr_wdata),
    .rdata  (rsp_rdata)
  );

  assign ready     = (state_q == RUN);
  assign rsp_valid = rsp_valid_q;

endmodule
